// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults, per-channel context type and round-robin pick helper
package seq_det_pkg;
  localparam int MAX_W = 16;
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;
  localparam int DEFAULT_LEN = 4;
  typedef struct packed {
    logic [MAX_W-1:0] hist;
    logic [4:0] fill;
  } ch_ctx_t;
  function automatic logic [MAX_W-1:0] rr_pick(input logic [MAX_W-1:0] valid, input logic [3:0] ptr, input int n);
    logic [MAX_W-1:0] g = '0;
    for (int i = 0; i < MAX_W; i++) begin
      int idx = (int'(ptr) + i) % n;
      if (i < n && g == '0 && valid[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction
endpackage

// File: rtl/seq_rr_arb.sv
// seq_rr_arb: round-robin arbiter; req in, one-hot grant and its index out, pointer advances past grant on advance
module seq_rr_arb
  import seq_det_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         req,
  input  logic                      advance,
  output logic [NUM_CH-1:0]         grant,
  output logic [$clog2(NUM_CH)-1:0] grant_idx
);
  localparam int PW = $clog2(NUM_CH);
  logic [PW-1:0] ptr;
  logic [MAX_W-1:0] pick;
  always_comb begin
    pick = rr_pick(MAX_W'(req), 4'(ptr), NUM_CH);
    grant_idx = '0;
    for (int i = 0; i < MAX_W; i++) if (pick[i]) grant_idx = PW'(i);
    grant = (|pick) ? NUM_CH'(1) << grant_idx : '0;
  end
  always_ff @(posedge clk)
    if (reset) ptr <= '0;
    else if (advance) ptr <= (grant_idx == PW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/seq_det_sched.sv
// seq_det_sched: one pattern detector time-shared round-robin over NUM_CH serial streams (req_valid/req_bit/req_ready, cfg_we/cfg_pattern/cfg_len/cfg_err, match_valid/match_ch/match_total, busy)
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH-1:0]          req_bit,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic                       cfg_we,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  output logic                       cfg_err,
  output logic                       match_valid,
  output logic [$clog2(NUM_CH)-1:0]  match_ch,
  output logic [CNT_W-1:0]           match_total,
  output logic                       busy
);
  localparam int LW = $clog2(PAT_W + 1);
  localparam int CW = $clog2(NUM_CH);
  logic [PAT_W-1:0] pattern;
  logic [LW-1:0] len;
  ch_ctx_t ctx [NUM_CH];
  logic [NUM_CH-1:0] grant;
  logic [CW-1:0] g;
  logic cfg_ok, xfer, hit;
  logic [MAX_W-1:0] nhist, lmask;
  logic [4:0] nfill;
  assign cfg_ok = cfg_we && cfg_len != '0 && cfg_len <= LW'(PAT_W);
  assign req_ready = (reset || cfg_ok) ? '0 : grant;
  assign xfer = |req_ready;
  assign busy = |req_valid;
  seq_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .clk(clk),
    .reset(reset),
    .req(req_valid),
    .advance(xfer),
    .grant(grant),
    .grant_idx(g)
  );
  always_comb begin
    nhist = {ctx[g].hist[MAX_W-2:0], req_bit[g]};
    nfill = (ctx[g].fill >= 5'(PAT_W)) ? 5'(PAT_W) : ctx[g].fill + 1'b1;
    lmask = MAX_W'((17'd1 << len) - 17'd1);
    hit = xfer && nfill >= 5'(len) && ((nhist ^ MAX_W'(pattern)) & lmask) == '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern <= PAT_W'(DEFAULT_PATTERN);
      len <= LW'(PAT_W < DEFAULT_LEN ? PAT_W : DEFAULT_LEN);
      for (int i = 0; i < NUM_CH; i++) ctx[i] <= '0;
      match_valid <= 1'b0;
      match_ch <= '0;
      match_total <= '0;
      cfg_err <= 1'b0;
    end else begin
      match_valid <= hit;
      cfg_err <= cfg_we && !cfg_ok;
      if (hit) begin
        match_ch <= g;
        if (!(&match_total)) match_total <= match_total + 1'b1;
      end
      if (cfg_ok) begin
        pattern <= cfg_pattern;
        len <= cfg_len;
        for (int i = 0; i < NUM_CH; i++) ctx[i] <= '0;
      end else if (xfer) ctx[g] <= {nhist, nfill};
    end
  end
endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: table-driven directed check of seq_det_sched (4 channels, 4-bit pattern, 3-bit counter)
module tb_seq_det_sched;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req_valid, req_bit, req_ready, cfg_pattern;
  logic cfg_we, cfg_err, match_valid, busy;
  logic [2:0] cfg_len, match_total;
  logic [1:0] match_ch;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  seq_det_sched #(.NUM_CH(4), .PAT_W(4), .CNT_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_bit(req_bit),
    .req_ready(req_ready),
    .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_err(cfg_err),
    .match_valid(match_valid),
    .match_ch(match_ch),
    .match_total(match_total),
    .busy(busy)
  );
  typedef struct {
    logic rst, we;
    logic [3:0] pat;
    logic [2:0] len;
    logic [3:0] v, b, rdy;
    logic mv;
    logic [1:0] mch;
    logic [2:0] tot;
    logic err;
  } vec_t;
  vec_t vq[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic rst, input logic we, input logic [3:0] pat, input logic [2:0] len,
                     input logic [3:0] v, input logic [3:0] b, input logic [3:0] rdy,
                     input logic mv, input logic [1:0] mch, input logic [2:0] tot, input logic err);
    vq.push_back('{rst, we, pat, len, v, b, rdy, mv, mch, tot, err});
  endtask
  initial begin
    reset = 1'b1;
    cfg_we = 1'b0;
    cfg_pattern = '0;
    cfg_len = '0;
    req_valid = '0;
    req_bit = '0;
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,0,0);
    add(0,0,0,0,4'b0001,4'b0000,4'b0001,0,0,0,0);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,0,0);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,0,0);
    add(0,0,0,0,4'b0000,4'b0000,4'b0000,1,0,1,0);
    add(0,1,4'b1011,4,4'b0001,4'b0001,4'b0000,0,0,1,0);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,1,0);
    add(0,0,0,0,4'b0001,4'b0000,4'b0001,0,0,1,0);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,1,0);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,1,0);
    add(0,0,0,0,4'b0001,4'b0000,4'b0001,1,0,2,0);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,2,0);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,2,0);
    add(0,0,0,0,4'b0000,4'b0000,4'b0000,1,0,3,0);
    add(0,0,0,0,4'b1111,4'b0000,4'b0010,0,0,3,0);
    add(0,0,0,0,4'b1111,4'b0000,4'b0100,0,0,3,0);
    add(0,0,0,0,4'b1111,4'b0000,4'b1000,0,0,3,0);
    add(0,0,0,0,4'b1111,4'b0000,4'b0001,0,0,3,0);
    add(0,0,0,0,4'b1111,4'b0000,4'b0010,0,0,3,0);
    add(0,0,0,0,4'b1111,4'b0000,4'b0100,0,0,3,0);
    add(0,1,4'b1011,4,4'b0110,4'b0000,4'b0000,0,0,3,0);
    add(0,0,0,0,4'b1110,4'b1110,4'b1000,0,0,3,0);
    add(0,0,0,0,4'b1110,4'b1110,4'b0010,0,0,3,0);
    add(0,0,0,0,4'b1110,4'b1100,4'b0100,0,0,3,0);
    add(0,0,0,0,4'b1110,4'b1000,4'b1000,0,0,3,0);
    add(0,0,0,0,4'b1110,4'b0000,4'b0010,0,0,3,0);
    add(0,0,0,0,4'b1110,4'b0010,4'b0100,0,0,3,0);
    add(0,0,0,0,4'b1110,4'b0110,4'b1000,0,0,3,0);
    add(0,0,0,0,4'b1110,4'b1110,4'b0010,0,0,3,0);
    add(0,0,0,0,4'b1110,4'b1110,4'b0100,0,0,3,0);
    add(0,0,0,0,4'b1110,4'b1110,4'b1000,0,0,3,0);
    add(0,0,0,0,4'b0110,4'b0110,4'b0010,0,0,3,0);
    add(0,0,0,0,4'b0100,4'b0100,4'b0100,1,1,4,0);
    add(0,0,0,0,4'b0000,4'b0000,4'b0000,1,2,5,0);
    add(0,0,0,0,4'b0000,4'b0000,4'b0000,0,0,5,0);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,5,0);
    add(0,0,0,0,4'b0001,4'b0000,4'b0001,0,0,5,0);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,5,0);
    add(0,1,4'b0110,3,4'b0001,4'b0001,4'b0000,0,0,5,0);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,5,0);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,5,0);
    add(0,0,0,0,4'b0001,4'b0000,4'b0001,0,0,5,0);
    add(0,1,4'b1011,4,4'b0000,4'b0000,4'b0000,1,0,6,0);
    add(0,1,4'b0000,0,4'b0001,4'b0001,4'b0001,0,0,6,0);
    add(0,0,0,0,4'b0001,4'b0000,4'b0001,0,0,6,1);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,6,0);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,6,0);
    add(0,0,0,0,4'b0000,4'b0000,4'b0000,1,0,7,0);
    add(0,1,4'b0000,5,4'b0000,4'b0000,4'b0000,0,0,7,0);
    add(0,0,0,0,4'b0000,4'b0000,4'b0000,0,0,7,1);
    add(0,0,0,0,4'b0001,4'b0000,4'b0001,0,0,7,0);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,7,0);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,7,0);
    add(0,0,0,0,4'b0000,4'b0000,4'b0000,1,0,7,0);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,7,0);
    add(0,0,0,0,4'b0001,4'b0000,4'b0001,0,0,7,0);
    add(0,0,0,0,4'b0001,4'b0001,4'b0001,0,0,7,0);
    add(1,1,4'b0000,0,4'b0001,4'b0001,4'b0000,0,0,7,0);
    add(0,0,0,0,4'b1111,4'b0001,4'b0001,0,0,0,0);
    add(0,0,0,0,4'b0000,4'b0000,4'b0000,0,0,0,0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    chk("reset ready", 32'(req_ready), 32'h0);
    chk("reset match_valid", 32'(match_valid), 32'h0);
    chk("reset match_ch", 32'(match_ch), 32'h0);
    chk("reset match_total", 32'(match_total), 32'h0);
    chk("reset cfg_err", 32'(cfg_err), 32'h0);
    chk("reset busy", 32'(busy), 32'h1);
    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst;
      cfg_we = vq[i].we;
      cfg_pattern = vq[i].pat;
      cfg_len = vq[i].len;
      req_valid = vq[i].v;
      req_bit = vq[i].b;
      #1;
      chk($sformatf("v%0d ready", i), 32'(req_ready), 32'(vq[i].rdy));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(|vq[i].v));
      chk($sformatf("v%0d match_valid", i), 32'(match_valid), 32'(vq[i].mv));
      chk($sformatf("v%0d match_total", i), 32'(match_total), 32'(vq[i].tot));
      chk($sformatf("v%0d cfg_err", i), 32'(cfg_err), 32'(vq[i].err));
      if (vq[i].mv) chk($sformatf("v%0d match_ch", i), 32'(match_ch), 32'(vq[i].mch));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
